sdram_mp: RTL

SDRAM_MP -- requirements
Module: sdram_mp

---
 rtl/sdram_mp.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sdram_mp.sv
// Multi-port SDRAM controller: fixed-length access slots, round-robin grant, one auto-precharged word per slot.
// Latency: ACTIVE at q=0, READ/WRITE at q=RASCAS_DELAY, dout/ack one clock after the q=L edge.
// Backpressure: a port holds req and its fields until ack; ungranted ports wait for a later slot.
module sdram_mp #(
    parameter int NPORTS        = 2,
    parameter int RASCAS_DELAY  = 2,
    parameter int CAS_LATENCY   = 2,
    parameter int REFRESH_SLOTS = 96
) (
    input  logic                  clk,
    input  logic                  init_n,
    inout  wire  [15:0]           sd_data,
    output logic [12:0]           sd_addr,
    output logic [1:0]            sd_dqm,
    output logic [1:0]            sd_ba,
    output logic                  sd_cs,
    output logic                  sd_ras,
    output logic                  sd_cas,
    output logic                  sd_we,
    output logic                  ready,
    input  logic [NPORTS-1:0]     req,
    input  logic [NPORTS-1:0]     we,
    input  logic [NPORTS*25-1:0]  addr,
    input  logic [NPORTS*16-1:0]  din,
    input  logic [NPORTS*2-1:0]   be,
    output logic [NPORTS*16-1:0]  dout,
    output logic [NPORTS-1:0]     ack
);

    localparam int L  = RASCAS_DELAY + CAS_LATENCY + 1;
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

    // Single-write mode, sequential burst of length 1, CAS latency from the parameter.
    localparam logic [12:0] MODE_WORD = {3'b000, 1'b1, 2'b00, 3'(CAS_LATENCY), 1'b0, 3'b000};

    logic [2:0]    q;
    logic [5:0]    init_cnt;
    logic [9:0]    ref_cnt;
    logic [PW-1:0] rr;
    logic          busy;
    logic [PW-1:0] port;
    logic          l_we;
    logic [8:0]    l_col;
    logic [15:0]   l_din;
    logic [1:0]    l_be;
    logic [3:0]    cmd;
    logic          dq_oe;
    logic [15:0]   dq_out;

    logic          found;
    logic [PW-1:0] pick;
    logic          sel_we;
    logic [23:0]   sel_addr;
    logic [15:0]   sel_din;
    logic [1:0]    sel_be;
    logic [NPORTS-1:0] addr_lsb_unused;

    assign {sd_cs, sd_ras, sd_cas, sd_we} = cmd;
    assign sd_data = dq_oe ? dq_out : 16'hzzzz;

    // Byte address bit 0 plays no part: byte lanes come from be alone.
    always_comb begin
        addr_lsb_unused = '0;
        for (int p = 0; p < NPORTS; p++) addr_lsb_unused[p] = addr[25*p];
    end

    // Round-robin search starting just after the last granted port, then mux out its fields.
    always_comb begin
        found = 1'b0;
        pick  = rr;
        for (int i = 1; i <= NPORTS; i++) begin
            if (!found && req[(int'(rr) + i) % NPORTS]) begin
                found = 1'b1;
                pick  = PW'((int'(rr) + i) % NPORTS);
            end
        end
        sel_we   = we[pick];
        sel_addr = addr[int'(pick)*25+1 +: 24];
        sel_din  = din[int'(pick)*16 +: 16];
        sel_be   = be[int'(pick)*2 +: 2];
    end

    // Slot sequencer: init commands, arbitration at q=0, column command, read capture and ack at q=L.
    always_ff @(posedge clk) begin
        if (!init_n) begin
            q        <= 3'd0;
            init_cnt <= 6'd63;
            ready    <= 1'b0;
            ack      <= '0;
            dout     <= '0;
            sd_dqm   <= 2'b11;
            cmd      <= CMD_INHIBIT;
            dq_oe    <= 1'b0;
            dq_out   <= 16'h0000;
            rr       <= PW'(NPORTS - 1);
            ref_cnt  <= 10'(REFRESH_SLOTS);
            busy     <= 1'b0;
            port     <= '0;
            l_we     <= 1'b0;
            l_col    <= 9'd0;
            l_din    <= 16'h0000;
            l_be     <= 2'b00;
            sd_addr  <= 13'd0;
            sd_ba    <= 2'b00;
        end else begin
            cmd   <= CMD_INHIBIT;
            dq_oe <= 1'b0;
            ack   <= '0;
            q     <= (q == 3'(L)) ? 3'd0 : q + 3'd1;

            if (q == 3'd0) begin
                if (!ready) begin
                    if (init_cnt == 6'd10) begin
                        cmd     <= CMD_PRECHARGE;
                        sd_addr <= 13'h0400;
                        sd_ba   <= 2'b00;
                    end else if (init_cnt >= 6'd2 && init_cnt <= 6'd9) begin
                        cmd     <= CMD_REFRESH;
                        ref_cnt <= 10'(REFRESH_SLOTS);
                    end else if (init_cnt == 6'd1) begin
                        cmd     <= CMD_LOAD_MODE;
                        sd_addr <= MODE_WORD;
                        sd_ba   <= 2'b00;
                    end
                end else if (ref_cnt == 10'd0 || !found) begin
                    // Overdue refresh wins; otherwise an idle slot is used to refresh early.
                    cmd     <= CMD_REFRESH;
                    ref_cnt <= 10'(REFRESH_SLOTS);
                end else begin
                    cmd     <= CMD_ACTIVE;
                    sd_ba   <= sel_addr[23:22];
                    sd_addr <= sel_addr[21:9];
                    busy    <= 1'b1;
                    port    <= pick;
                    rr      <= pick;
                    l_we    <= sel_we;
                    l_col   <= sel_addr[8:0];
                    l_din   <= sel_din;
                    l_be    <= sel_be;
                end
            end

            if (busy && q == 3'(RASCAS_DELAY)) begin
                cmd     <= l_we ? CMD_WRITE : CMD_READ;
                sd_addr <= {2'b00, 1'b1, 1'b0, l_col};
                sd_dqm  <= l_we ? ~l_be : 2'b00;
                dq_oe   <= l_we;
                dq_out  <= l_din;
            end

            // Masks return high after a write; after a read they stay low to cover the data beat.
            if (busy && l_we && q == 3'(RASCAS_DELAY + 1)) sd_dqm <= 2'b11;

            if (q == 3'(L)) begin
                if (ref_cnt != 10'd0) ref_cnt <= ref_cnt - 10'd1;
                if (!ready) begin
                    if (init_cnt != 6'd0) init_cnt <= init_cnt - 6'd1;
                    if (init_cnt == 6'd1) ready <= 1'b1;
                end
                if (busy) begin
                    busy <= 1'b0;
                    for (int p = 0; p < NPORTS; p++) begin
                        if (PW'(p) == port) begin
                            ack[p] <= 1'b1;
                            if (!l_we && l_be[0]) dout[p*16 +: 8]   <= sd_data[7:0];
                            if (!l_we && l_be[1]) dout[p*16+8 +: 8] <= sd_data[15:8];
                        end
                    end
                end
            end
        end
    end

endmodule
